// File: rtl/decode_if.sv
// Fetch-to-decode-to-execute handshake bundle. The decode stage takes the
// slave view; whatever drives fetch and consumes execute takes the master view.
interface decode_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 19
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [XLEN-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_ctrl
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_ctrl
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode stage with a two-entry skid buffer.
// Decode is combinational on the offered instruction; the control bundle is
// captured alongside inst/pc so execute sees everything from registers.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int EN_M   = 0,
  parameter int CTRL_W = 19
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  decode_if.slave   bus
);

  localparam bit RV64  = (XLEN == 64);
  localparam bit HAS_M = (EN_M != 0);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [6:0] FN7_BASE = 7'b0000000;
  localparam logic [6:0] FN7_ALT  = 7'b0100000;
  localparam logic [6:0] FN7_MUL  = 7'b0000001;

  // Field order is MSB first so the packed layout matches the out_ctrl bit map.
  typedef struct packed {
    logic       illegal;
    logic       is_fencei;
    logic       is_fence;
    logic       is_store;
    logic       is_load;
    logic       is_jmp;
    logic       is_branch;
    logic       jmp_reg;
    logic       add_pc;
    logic       ld_upper;
    logic       rd_w;
    logic       mul_div;
    logic       alu_word;
    logic       alu_sra;
    logic       alu_sub;
    logic       alu_imm;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0]       inst;
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [2:0]  fn3;
  logic [6:0]  fn7;
  ctrl_t       dec;
  logic        bad;

  assign inst = bus.in_inst;
  assign opc  = inst[6:0];
  assign fn3  = inst[14:12];
  assign fn7  = inst[31:25];

  // Combinational decode of the offered instruction into the control bundle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned, which is what would otherwise infer a latch.
    dec = '0;
    bad = 1'b0;
    case (opc)
      OPC_LUI: begin
        dec.ld_upper = 1'b1;
        dec.rd_w     = 1'b1;
        dec.alu_op   = fn3;
      end
      OPC_AUIPC: begin
        dec.add_pc = 1'b1;
        dec.rd_w   = 1'b1;
        dec.alu_op = fn3;
      end
      OPC_OP_IMM: begin
        dec.alu_imm = 1'b1;
        dec.rd_w    = 1'b1;
        dec.alu_op  = fn3;
        dec.alu_sra = (fn3 == 3'b101) && inst[30];
        // Shift immediates carry the funct field; RV64 uses a 6-bit shamt.
        if (fn3 == 3'b001 || fn3 == 3'b101) begin
          if (RV64) bad = !(inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000);
          else      bad = !(fn7 == FN7_BASE || fn7 == FN7_ALT);
        end
      end
      OPC_OP_IMM32: begin
        if (RV64) begin
          dec.alu_imm  = 1'b1;
          dec.rd_w     = 1'b1;
          dec.alu_word = 1'b1;
          dec.alu_op   = fn3;
          dec.alu_sra  = (fn3 == 3'b101) && inst[30];
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP: begin
        dec.rd_w    = 1'b1;
        dec.alu_op  = fn3;
        dec.alu_sub = (fn3 == 3'b000) && (fn7 == FN7_ALT);
        dec.alu_sra = (fn3 == 3'b101) && inst[30];
        dec.mul_div = HAS_M && (fn7 == FN7_MUL);
        case (fn7)
          FN7_BASE: bad = 1'b0;
          FN7_ALT:  bad = !(fn3 == 3'b000 || fn3 == 3'b101);
          FN7_MUL:  bad = !HAS_M;
          default:  bad = 1'b1;
        endcase
      end
      OPC_OP32: begin
        if (RV64) begin
          dec.rd_w     = 1'b1;
          dec.alu_word = 1'b1;
          dec.alu_op   = fn3;
          dec.alu_sub  = (fn3 == 3'b000) && (fn7 == FN7_ALT);
          dec.alu_sra  = (fn3 == 3'b101) && inst[30];
          dec.mul_div  = HAS_M && (fn7 == FN7_MUL);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_JAL: begin
        dec.is_jmp = 1'b1;
        dec.rd_w   = 1'b1;
      end
      OPC_JALR: begin
        dec.is_jmp  = 1'b1;
        dec.rd_w    = 1'b1;
        dec.alu_imm = 1'b1;
        dec.jmp_reg = (fn3 == 3'b000);
        bad         = (fn3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.alu_op    = fn3;
        bad           = (fn3 == 3'b010) || (fn3 == 3'b011);
      end
      OPC_LOAD: begin
        dec.is_load = 1'b1;
        dec.rd_w    = 1'b1;
        dec.alu_imm = 1'b1;
        bad = (fn3 == 3'b111) || (!RV64 && (fn3 == 3'b011 || fn3 == 3'b110));
      end
      OPC_STORE: begin
        dec.is_store = 1'b1;
        dec.alu_imm  = 1'b1;
        bad = fn3[2] || (!RV64 && fn3 == 3'b011);
      end
      OPC_MISC_MEM: begin
        dec.alu_op    = fn3;
        dec.is_fence  = (fn3 == 3'b000);
        dec.is_fencei = (fn3 == 3'b001);
        bad           = (fn3 >= 3'b010);
      end
      OPC_SYSTEM: begin
        dec.alu_op = fn3;
      end
      default: bad = 1'b1;
    endcase
    // Compressed encodings never match a full opcode above; kept explicit.
    if (inst[1:0] != 2'b11) bad = 1'b1;
    // An illegal instruction must not trigger any side effect downstream.
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  entry_t in_ent;
  entry_t head;
  entry_t skid;
  state_t state;
  state_t state_nxt;
  logic   rdy_q;
  logic   vld_q;
  logic   accept;
  logic   pop;

  assign in_ent = '{inst: bus.in_inst, pc: bus.in_pc, ctrl: dec};
  assign accept = bus.in_valid && rdy_q;
  assign pop    = vld_q && bus.out_ready;

  // Occupancy transition; flush overrides any concurrent accept or pop.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !pop)      state_nxt = TWO;
          else if (!accept && pop) state_nxt = EMPTY;
        end
        TWO:     if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Buffer state, registered handshake outputs and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two entries are plain registers, not a RAM, so they are
      // cleared here to give defined out_* values straight out of reset.
      state <= EMPTY;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      head  <= '0;
      skid  <= '0;
    end else begin
      // NOTE: non-blocking assignments let head and skid swap roles in one
      // edge without depending on statement order.
      state <= state_nxt;
      rdy_q <= (state_nxt != TWO);
      vld_q <= (state_nxt != EMPTY);
      if (!flush) begin
        case (state)
          EMPTY: if (accept) head <= in_ent;
          ONE: begin
            if (accept && pop) head <= in_ent;
            else if (accept)   skid <= in_ent;
          end
          TWO:     if (pop) head <= skid;
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_inst  = head.inst;
  assign bus.out_pc    = head.pc;
  assign bus.out_ctrl  = head.ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit base-only instance and a 64-bit
// instance with multiply/divide run side by side on identical stimulus.
module tb_decode_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  decode_if #(.XLEN(32), .CTRL_W(19)) if32 ();
  decode_if #(.XLEN(64), .CTRL_W(19)) if64 ();

  decode_stage #(.XLEN(32), .EN_M(0), .CTRL_W(19)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32)
  );
  decode_stage #(.XLEN(64), .EN_M(1), .CTRL_W(19)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Hand-decoded vectors: instruction, expected ctrl on RV32 (no M), on RV64 (M).
  logic [31:0] dv_inst [11] = '{
    32'h00500093, 32'h40208033, 32'h40005093, 32'h0000503b, 32'h02208033,
    32'h00000000, 32'h00001067, 32'h00003083, 32'h0000100f, 32'h000010b7,
    32'h02009093
  };
  logic [18:0] dv_c32 [11] = '{
    19'h00108, 19'h00110, 19'h0012D, 19'h40000, 19'h40000,
    19'h40000, 19'h40000, 19'h40000, 19'h20001, 19'h00301,
    19'h40000
  };
  logic [18:0] dv_c64 [11] = '{
    19'h00108, 19'h00110, 19'h0012D, 19'h00145, 19'h00180,
    19'h40000, 19'h40000, 19'h04108, 19'h20001, 19'h00301,
    19'h00109
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    if32.in_valid = v;
    if32.in_inst  = inst;
    if32.in_pc    = pc;
    if64.in_valid = v;
    if64.in_inst  = inst;
    if64.in_pc    = {32'h0, pc};
  endtask

  task automatic set_ready(input logic r);
    if32.out_ready = r;
    if64.out_ready = r;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0);
    set_ready(1'b1);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", if32.out_valid); end
    n_cmp++; if (if32.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", if32.in_ready); end
    n_cmp++; if (if32.out_inst !== 32'h0) begin n_err++; $display("FAIL reset_out_inst: got %h want 0", if32.out_inst); end
    n_cmp++; if (if32.out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc: got %h want 0", if32.out_pc); end
    n_cmp++; if (if32.out_ctrl !== 19'h0) begin n_err++; $display("FAIL reset_out_ctrl: got %h want 0", if32.out_ctrl); end
    n_cmp++; if (if64.out_valid !== 1'b0 || if64.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_rv64_hs: got v=%b r=%b want v=0 r=1", if64.out_valid, if64.in_ready); end
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    n_cmp++; if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_hs: got v=%b r=%b want v=0 r=1", if32.out_valid, if32.in_ready); end
  endtask

  task automatic test_addi();
    set_ready(1'b1);
    drive(1'b1, 32'h00500093, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n_cmp++; if (if32.out_valid !== 1'b1) begin n_err++; $display("FAIL addi_out_valid: got %b want 1", if32.out_valid); end
    n_cmp++; if (if32.out_ctrl !== 19'h00108) begin n_err++; $display("FAIL addi_ctrl: got %h want 00108", if32.out_ctrl); end
    n_cmp++; if (if32.out_pc !== 32'h0) begin n_err++; $display("FAIL addi_pc: got %h want 0", if32.out_pc); end
    n_cmp++; if (if32.out_inst !== 32'h00500093) begin n_err++; $display("FAIL addi_inst: got %h want 00500093", if32.out_inst); end
    step();
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drain: got %b want 0", if32.out_valid); end
  endtask

  task automatic test_decode();
    set_ready(1'b1);
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, dv_inst[i], 32'h1000 + 32'(4 * i));
      step();
      n_cmp++; if (if32.out_valid !== 1'b1 || if32.out_ctrl !== dv_c32[i]) begin n_err++; $display("FAIL decode32[%0d] %h: got v=%b ctrl=%h want v=1 ctrl=%h", i, dv_inst[i], if32.out_valid, if32.out_ctrl, dv_c32[i]); end
      n_cmp++; if (if64.out_valid !== 1'b1 || if64.out_ctrl !== dv_c64[i]) begin n_err++; $display("FAIL decode64[%0d] %h: got v=%b ctrl=%h want v=1 ctrl=%h", i, dv_inst[i], if64.out_valid, if64.out_ctrl, dv_c64[i]); end
      n_cmp++; if (if32.out_pc !== 32'h1000 + 32'(4 * i)) begin n_err++; $display("FAIL decode_pc[%0d]: got %h want %h", i, if32.out_pc, 32'h1000 + 32'(4 * i)); end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++; $display("FAIL decode_drain: got %b want 0", if32.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bp_inst [4];
    int src;
    int pops;
    int low;
    logic fire_in;
    logic fire_out;
    logic stalled;
    logic [31:0] head_pc;
    bp_inst = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
    src  = 0;
    pops = 0;
    low  = 0;
    set_ready(1'b1);
    drive(1'b1, bp_inst[0], 32'h200);
    for (int cyc = 0; cyc < 12; cyc++) begin
      fire_in  = if32.in_valid && if32.in_ready;
      fire_out = if32.out_valid && if32.out_ready;
      stalled  = if32.out_valid && !if32.out_ready;
      head_pc  = if32.out_pc;
      if (fire_out) begin
        n_cmp++;
        if (pops >= 4) begin
          n_err++; $display("FAIL b2b_duplicate: got extra pc=%h want none", if32.out_pc);
        end else if (if32.out_pc !== 32'h200 + 32'(4 * pops) || if32.out_inst !== bp_inst[pops]) begin
          n_err++; $display("FAIL b2b_order[%0d]: got pc=%h inst=%h want pc=%h inst=%h", pops, if32.out_pc, if32.out_inst, 32'h200 + 32'(4 * pops), bp_inst[pops]);
        end
        pops++;
      end
      step();
      if (stalled) begin
        n_cmp++; if (if32.out_valid !== 1'b1 || if32.out_pc !== head_pc) begin n_err++; $display("FAIL b2b_stall_hold: got v=%b pc=%h want v=1 pc=%h", if32.out_valid, if32.out_pc, head_pc); end
      end
      if (fire_in) src++;
      if (!if32.in_ready) low++;
      if (src < 4) drive(1'b1, bp_inst[src], 32'h200 + 32'(4 * src));
      else         drive(1'b0, 32'h0, 32'h0);
      set_ready(!(cyc == 0 || cyc == 1));
    end
    n_cmp++; if (pops != 4) begin n_err++; $display("FAIL b2b_pop_count: got %0d want 4", pops); end
    n_cmp++; if (src != 4) begin n_err++; $display("FAIL b2b_accept_count: got %0d want 4", src); end
    n_cmp++; if (low != 2) begin n_err++; $display("FAIL b2b_in_ready_low: got %0d cycles want 2", low); end
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", if32.out_valid); end
  endtask

  task automatic test_flush();
    set_ready(1'b0);
    drive(1'b1, 32'h00a00093, 32'h300);
    step();
    drive(1'b1, 32'h00b00093, 32'h304);
    step();
    n_cmp++; if (if32.in_ready !== 1'b0 || if32.out_valid !== 1'b1) begin n_err++; $display("FAIL flush_two_state: got r=%b v=%b want r=0 v=1", if32.in_ready, if32.out_valid); end
    drive(1'b1, 32'h00c00093, 32'h308);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    n_cmp++; if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_hs: got v=%b r=%b want v=0 r=1", if32.out_valid, if32.in_ready); end
    n_cmp++; if (if64.out_valid !== 1'b0 || if64.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_hs64: got v=%b r=%b want v=0 r=1", if64.out_valid, if64.in_ready); end
    set_ready(1'b1);
    step();
    step();
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_leak: got v=%b pc=%h want v=0", if32.out_valid, if32.out_pc); end
    drive(1'b1, 32'h00d00093, 32'h30c);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n_cmp++; if (if32.out_valid !== 1'b1 || if32.out_pc !== 32'h30c || if32.out_inst !== 32'h00d00093) begin n_err++; $display("FAIL flush_resume: got v=%b pc=%h inst=%h want v=1 pc=30c inst=00d00093", if32.out_valid, if32.out_pc, if32.out_inst); end
    step();
    n_cmp++; if (if32.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_resume_drain: got v=%b pc=%h want v=0", if32.out_valid, if32.out_pc); end
  endtask

  task automatic test_async_reset();
    set_ready(1'b0);
    drive(1'b1, 32'h00e00093, 32'h400);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n_cmp++; if (if32.out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre: got v=%b want 1", if32.out_valid); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin n_err++; $display("FAIL areset_hs: got v=%b r=%b want v=0 r=1", if32.out_valid, if32.in_ready); end
    n_cmp++; if (if32.out_pc !== 32'h0 || if32.out_ctrl !== 19'h0) begin n_err++; $display("FAIL areset_data: got pc=%h ctrl=%h want 0/0", if32.out_pc, if32.out_ctrl); end
    #2 rst_n = 1'b1;
    step();
    set_ready(1'b1);
    drive(1'b1, 32'h40208033, 32'h500);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n_cmp++; if (if32.out_valid !== 1'b1 || if32.out_pc !== 32'h500 || if32.out_ctrl !== 19'h00110) begin n_err++; $display("FAIL areset_resume: got v=%b pc=%h ctrl=%h want v=1 pc=500 ctrl=00110", if32.out_valid, if32.out_pc, if32.out_ctrl); end
    step();
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0);
    set_ready(1'b1);
    test_reset();
    test_addi();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled instruction decode stage, parametrised in XLEN and optional extension support. Sits between fetch and execute. Accepts one instruction per cycle on a valid/ready handshake, decodes it into a fixed control bundle, flags illegal encodings, and holds results in a two-entry skid buffer so that a stalled execute stage never loses or duplicates an instruction. A synchronous flush discards all buffered work.

## Interface
- `XLEN`, 32: datapath width; only 32 and 64 are legal.
- `EN_M`, 0: when 1, OP/OP-32 with fn7 = 0000001 decode as multiply/divide; when 0, they are illegal.
- `CTRL_W`, 19: control bundle width; fixed, exposed for consumers.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous discard of all buffered entries.
- `in_valid` in 1: fetch offers `in_inst`/`in_pc`.
- `in_ready` out 1: stage accepts this cycle; registered.
- `in_inst` in 32: instruction word.
- `in_pc` in XLEN: address of `in_inst`.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: execute consumes the head this cycle.
- `out_inst` out 32: head instruction.
- `out_pc` out XLEN: head PC.
- `out_ctrl` out CTRL_W: head control bundle. Bit map: [2:0] alu_op, 3 alu_imm, 4 alu_sub, 5 alu_sra, 6 alu_word, 7 mul_div, 8 rd_w, 9 ld_upper, 10 add_pc, 11 jmp_reg, 12 is_branch, 13 is_jmp, 14 is_load, 15 is_store, 16 is_fence, 17 is_fencei, 18 illegal.

## Operation
- Decode is combinational on `in_inst` and is captured together with `in_inst`/`in_pc` when `in_valid && in_ready`.
- Opcodes recognised: LUI, AUIPC, OP-IMM, OP, JAL, JALR, BRANCH, LOAD, STORE, MISC-MEM, SYSTEM, and OP-IMM-32/OP-32 when XLEN = 64.
- alu_op = 000 for jumps, loads and stores; otherwise fn3. alu_imm covers I-type (JALR, LOAD, OP-IMM, OP-IMM-32) and S-type.
- alu_sub: OP or OP-32, fn3 000, fn7 0100000. alu_sra: OP/OP-IMM/OP-32/OP-IMM-32 with fn3 101 and inst[30] = 1.
- alu_word: opcode is OP-32 or OP-IMM-32. mul_div: OP or OP-32 with fn7 0000001 and EN_M = 1.
- rd_w is set for R, I, U and J types; it is forced to 0 when illegal. jmp_reg is set for JALR with fn3 000. is_fence is set for MISC-MEM with fn3 000. is_fencei is set for MISC-MEM with fn3 001.
- illegal = 1 for any of the following:
  - unknown opcode, or inst[1:0] ≠ 11;
  - JALR with fn3 ≠ 000; BRANCH with fn3 010 or 011;
  - LOAD with fn3 111, or with fn3 011/110 when XLEN = 32;
  - STORE with fn3 ≥ 100, or with fn3 011 when XLEN = 32;
  - OP with fn7 other than 0000000 or 0100000 (0000001 is also allowed when EN_M = 1), or fn7 0100000 with fn3 other than 000 or 101;
  - OP-IMM shifts: for XLEN = 32, fn7 not 0000000/0100000; for XLEN = 64, inst[31:26] not 000000/010000;
  - MISC-MEM with fn3 ≥ 010.
- When illegal = 1, every other ctrl bit is 0.
- Buffer occupancy states, with entries held in order head then skid:
  - EMPTY: no entries.
  - ONE: head only.
  - TWO: head and skid.
- Transitions:
  - accept with no pop: EMPTY→ONE, ONE→TWO.
  - pop with no accept: ONE→EMPTY, TWO→ONE (skid moves to head).
  - accept and pop together: ONE stays ONE, with the head replaced by the new entry.
- Because `in_ready` is registered, TWO cannot accept.
- `in_ready` = next state ≠ TWO. It is never combinationally dependent on `out_ready`.
- `flush` has priority over accept and pop: next state is EMPTY and any concurrent input is dropped.

## Timing
- Reset (`rst_n` low, asynchronous): state EMPTY, `out_valid` = 0, `in_ready` = 1, and `out_inst`, `out_pc`, `out_ctrl` all 0.
- Latency: an instruction accepted at edge N appears on `out_*` with `out_valid` = 1 after edge N; `out_*` are register outputs.
- Throughput: one instruction per cycle while `out_ready` stays 1.
- The head is stable while `out_valid && !out_ready`.
- Flush asserted at edge N gives `out_valid` = 0 and `in_ready` = 1 after N.
- Reset released mid-stream: the buffer is empty and the handshake resumes cleanly from EMPTY.

## Test plan
- Reset then stream `00500093` (addi x1,x0,5) at pc 0, with `out_ready` = 1 → next cycle: `out_valid` = 1, alu_imm = 1, rd_w = 1, alu_op = 000, illegal = 0, `out_pc` = 0.
- Stream 4 instructions back-to-back with `out_ready` dropped for 2 cycles mid-stream → `in_ready` falls after the second buffered entry; all 4 emerge in order, with no loss and no duplicates.
- `40208033` (sub) → alu_sub = 1. `40005093` (srai) → alu_sra = 1. `0000503b` (srlw) → alu_word = 1 with XLEN = 64, and illegal = 1 with XLEN = 32.
- `02208033` (mul) → mul_div = 1 when EN_M = 1. With EN_M = 0 → illegal = 1 and rd_w = 0.
- TWO state with flush and `in_valid` asserted together → next cycle `out_valid` = 0 and `in_ready` = 1, and the flushed and offered instructions never appear.
- Assert `rst_n` low asynchronously while in state ONE → `out_valid` drops immediately, without waiting for a clock edge.
